// File: rtl/draw_cmd_issuer_pkg.sv
// Shared draw-command encoding: word layouts, FSM encoding and default screen limits.
// The painter-side decode imports the same definitions, so both ends agree on field positions.
package draw_cmd_issuer_pkg;

    localparam int DEF_MAX_LINE = 119;
    localparam int DEF_MAX_COL  = 319;

    typedef logic [6:0]  line_t;
    typedef logic [8:0]  col_t;
    typedef logic [2:0]  color_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2
    } state_t;

    typedef struct packed {
        line_t  top;
        line_t  bottom;
        col_t   left;
        col_t   right;
        color_t color;
    } span_t;

    // W0: {line[15:9], left[8:0]}
    function automatic word_t pack_w0(input line_t line, input col_t left);
        return {line, left};
    endfunction

    // W1: {color[15:13], 4'b0, right[8:0]}
    function automatic word_t pack_w1(input color_t color, input col_t right);
        return {color, 4'b0000, right};
    endfunction

endpackage

// File: rtl/draw_cmd_issuer_span_normalize.sv
// Orders the span corners (top<=bottom, left<=right), then clamps them to the screen limits.
// Purely combinational; the parent registers the result when it accepts a request.
// No handshake of its own.
module span_normalize
    import draw_cmd_issuer_pkg::*;
#(
    parameter int MAX_LINE = DEF_MAX_LINE,
    parameter int MAX_COL  = DEF_MAX_COL
) (
    input  span_t raw,
    output span_t norm
);

    line_t lo_line, hi_line;
    col_t  lo_col,  hi_col;

    always_comb begin
        lo_line = raw.top;
        hi_line = raw.bottom;
        lo_col  = raw.left;
        hi_col  = raw.right;
        if (raw.top > raw.bottom) begin
            lo_line = raw.bottom;
            hi_line = raw.top;
        end
        if (raw.left > raw.right) begin
            lo_col = raw.right;
            hi_col = raw.left;
        end

        // Clamp after swapping so an out-of-range corner cannot reorder the span.
        norm        = raw;
        norm.top    = (lo_line > line_t'(MAX_LINE)) ? line_t'(MAX_LINE) : lo_line;
        norm.bottom = (hi_line > line_t'(MAX_LINE)) ? line_t'(MAX_LINE) : hi_line;
        norm.left   = (lo_col  > col_t'(MAX_COL))   ? col_t'(MAX_COL)   : lo_col;
        norm.right  = (hi_col  > col_t'(MAX_COL))   ? col_t'(MAX_COL)   : hi_col;
    end

endmodule

// File: rtl/draw_cmd_issuer.sv
// Turns a span-fill request into pairs of draw-queue words, one pair per scanline.
// Latency: first word the cycle after accept, then one word per cycle; done one cycle after the last word.
// Backpressure: full stalls the current word in place; abort ends the fill on a pair boundary.
module draw_cmd_issuer
    import draw_cmd_issuer_pkg::*;
#(
    parameter int MAX_LINE = DEF_MAX_LINE,
    parameter int MAX_COL  = DEF_MAX_COL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_top,
    input  logic [6:0]  req_bottom,
    input  logic [8:0]  req_left,
    input  logic [8:0]  req_right,
    input  logic [2:0]  req_color,
    input  logic        abort,
    input  logic        full,
    output logic        we,
    output logic [15:0] data,
    output logic        busy,
    output logic        done
);

    state_t state;
    span_t  span_q;
    span_t  raw;
    span_t  norm;
    line_t  cur_line;
    logic   abort_pend;
    logic   accept;

    assign raw = '{top: req_top, bottom: req_bottom, left: req_left,
                   right: req_right, color: req_color};

    span_normalize #(
        .MAX_LINE (MAX_LINE),
        .MAX_COL  (MAX_COL)
    ) u_norm (
        .raw  (raw),
        .norm (norm)
    );

    // Holding ready low during the done cycle keeps fills at least one cycle apart.
    assign req_ready = (state == ST_IDLE) && !done;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    // A W0 with an abort already pending is dropped so a pair is never started.
    assign we        = (((state == ST_W0) && !abort_pend) || (state == ST_W1)) && !full;

    always_comb begin
        data = '0;
        case (state)
            ST_W0:   data = pack_w0(cur_line, span_q.left);
            ST_W1:   data = pack_w1(span_q.color, span_q.right);
            default: data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            span_q     <= '0;
            cur_line   <= '0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (accept) begin
                        span_q   <= norm;
                        cur_line <= norm.top;
                        state    <= ST_W0;
                    end
                end
                ST_W0: begin
                    if (abort_pend) begin
                        abort_pend <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        if (abort) abort_pend <= 1'b1;
                        if (!full) state <= ST_W1;
                    end
                end
                ST_W1: begin
                    if (!full) begin
                        if ((cur_line == span_q.bottom) || abort_pend || abort) begin
                            abort_pend <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            cur_line <= cur_line + 7'd1;
                            state    <= ST_W0;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_cmd_issuer.sv
// Bench for draw_cmd_issuer: fixed vectors, stall/abort/reset sequences and random fills vs a word-list model.
module tb_draw_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  req_top = '0;
    logic [6:0]  req_bottom = '0;
    logic [8:0]  req_left = '0;
    logic [8:0]  req_right = '0;
    logic [2:0]  req_color = '0;
    logic        abort = 1'b0;
    logic        full = 1'b0;
    logic        req_ready, we, busy, done;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [15:0] cap[$];
    int          cap_cyc[$];
    logic [15:0] exp_q[$];

    draw_cmd_issuer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_top(req_top), .req_bottom(req_bottom), .req_left(req_left),
        .req_right(req_right), .req_color(req_color), .abort(abort), .full(full),
        .we(we), .data(data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: a word seen with we=1 here is transferred on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (we) begin
                cap.push_back(data);
                cap_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req_valid && req_ready) acc_cyc = cyc;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: one {line,left} / {color,0,right} pair for every line of the ordered, clamped span.
    task automatic build_exp(input int top, input int bot, input int left, input int right,
                             input int color);
        int t, b, l, r;
        t = (top < bot) ? top : bot;
        b = (top < bot) ? bot : top;
        l = (left < right) ? left : right;
        r = (left < right) ? right : left;
        if (t > 119) t = 119;
        if (b > 119) b = 119;
        if (l > 319) l = 319;
        if (r > 319) r = 319;
        exp_q.delete();
        for (int ln = t; ln <= b; ln++) begin
            exp_q.push_back(16'((ln << 9) | l));
            exp_q.push_back(16'((color << 13) | r));
        end
    endtask

    task automatic compare_cap(input string nm);
        int bad;
        bad = 0;
        check({nm, "_count"}, cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) bad++;
        check({nm, "_words_bad"}, bad, 0);
    endtask

    // full_mode: 0 never full, 1 random 30%, 2 full for 3 cycles in the first W1.
    task automatic run_fill(input int top, input int bot, input int left, input int right,
                            input int color, input int full_mode, input int abort_at);
        int guard, hold;
        cap.delete();
        cap_cyc.delete();
        done_cnt = 0;
        hold = 0;
        guard = 0;
        while (!req_ready && guard < 50) begin step(); guard++; end
        check("ready_before_req", int'(req_ready), 1);
        req_top = 7'(top); req_bottom = 7'(bot);
        req_left = 9'(left); req_right = 9'(right); req_color = 3'(color);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            abort = (abort_at >= 0) && (cap.size() == abort_at);
            case (full_mode)
                1: full = ($urandom_range(0, 99) < 30);
                2: begin
                    if (cap.size() == 1 && hold < 3) begin
                        full = 1'b1;
                        hold++;
                        #1;
                        check("stall_we", int'(we), 0);
                        check("stall_data", int'(data), int'(exp_q[1]));
                    end else begin
                        full = 1'b0;
                    end
                end
                default: full = 1'b0;
            endcase
            step();
            guard++;
        end
        abort = 1'b0;
        full = 1'b0;
        check("done_seen", int'(done_cnt > 0), 1);
        repeat (3) step();
        check("done_once", done_cnt, 1);
        check("ready_after_done", int'(req_ready), 1);
        check("busy_after_done", int'(busy), 0);
    endtask

    typedef struct {
        int top, bot, left, right, color;
        int nwords;
        logic [15:0] first, last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{top: 5,   bot: 6,   left: 10,  right: 20,  color: 5, nwords: 4,   first: 16'h0A0A, last: 16'hA014};
        vecs[1] = '{top: 50,  bot: 40,  left: 300, right: 2,   color: 0, nwords: 22,  first: 16'h5002, last: 16'h012C};
        vecs[2] = '{top: 127, bot: 127, left: 0,   right: 511, color: 7, nwords: 2,   first: 16'hEE00, last: 16'hE13F};
        vecs[3] = '{top: 0,   bot: 0,   left: 0,   right: 0,   color: 0, nwords: 2,   first: 16'h0000, last: 16'h0000};
        vecs[4] = '{top: 119, bot: 0,   left: 319, right: 0,   color: 2, nwords: 240, first: 16'h0000, last: 16'h413F};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", int'(we), 0);
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(req_ready), 1);
        reset = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_ignored", int'(busy), 0);

        // Fixed vectors, full never asserted: exact timing and content
        foreach (vecs[i]) begin
            build_exp(vecs[i].top, vecs[i].bot, vecs[i].left, vecs[i].right, vecs[i].color);
            run_fill(vecs[i].top, vecs[i].bot, vecs[i].left, vecs[i].right, vecs[i].color, 0, -1);
            check($sformatf("vec%0d_count", i), cap.size(), vecs[i].nwords);
            if (cap.size() > 0) begin
                check($sformatf("vec%0d_first", i), int'(cap[0]), int'(vecs[i].first));
                check($sformatf("vec%0d_last", i), int'(cap[cap.size()-1]), int'(vecs[i].last));
                check($sformatf("vec%0d_latency", i), cap_cyc[0], acc_cyc + 1);
                check($sformatf("vec%0d_back2back", i), cap_cyc[cap.size()-1] - cap_cyc[0],
                      vecs[i].nwords - 1);
            end
            check($sformatf("vec%0d_done_cyc", i), done_cyc, acc_cyc + 1 + vecs[i].nwords);
            compare_cap($sformatf("vec%0d", i));
        end

        // Queue full for 3 cycles in W1: no duplicate, no loss
        build_exp(5, 6, 10, 20, 5);
        run_fill(5, 6, 10, 20, 5, 2, -1);
        compare_cap("stall");

        // Abort during W1 of the second line of a 10-line fill
        build_exp(10, 19, 1, 2, 3);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        run_fill(10, 19, 1, 2, 3, 0, 3);
        compare_cap("abort");

        // Reset during W0, then a clean restart
        build_exp(5, 6, 10, 20, 5);
        req_top = 7'd5; req_bottom = 7'd6; req_left = 9'd10; req_right = 9'd20; req_color = 3'd5;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("w0_we_before_reset", int'(we), 1);
        done_cnt = 0;
        reset = 1'b0;
        #1;
        check("mid_rst_we", int'(we), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(req_ready), 1);
        check("mid_rst_data", int'(data), 0);
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_no_done", done_cnt, 0);
        run_fill(5, 6, 10, 20, 5, 0, -1);
        compare_cap("restart");

        // Random fills with random queue backpressure
        for (int n = 0; n < 30; n++) begin
            int t, b, l, r, c;
            t = $urandom_range(0, 127);
            b = (n % 3 == 0) ? $urandom_range(0, 127) : (t + $urandom_range(0, 6)) % 128;
            l = $urandom_range(0, 511);
            r = $urandom_range(0, 511);
            c = $urandom_range(0, 7);
            build_exp(t, b, l, r, c);
            run_fill(t, b, l, r, c, 1, -1);
            compare_cap($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_cmd_issuer.md
DRAW_CMD_ISSUER -- requirements
Module: draw_cmd_issuer

Interface
REQ-001 clk  input  1  system clock, same domain as the draw-unit command queue write port.
REQ-002 reset  input  1  asynchronous, active-low reset; one clock only in this block.
REQ-003 req_valid  input  1  span-fill request present.
REQ-004 req_ready  output  1  request accepted on a clk edge where req_valid=1 and req_ready=1.
REQ-005 req_top  input  7  first scanline of the fill.
REQ-006 req_bottom  input  7  last scanline of the fill.
REQ-007 req_left  input  9  left pixel column.
REQ-008 req_right  input  9  right pixel column.
REQ-009 req_color  input  3  {R,G,B}.
REQ-010 abort  input  1  stop the fill at the next command-pair boundary.
REQ-011 full  input  1  draw-unit command queue full; no word is accepted while high.
REQ-012 we  output  1  queue write strobe.
REQ-013 data  output  16  queue write word.
REQ-014 busy  output  1  high while a fill is in progress.
REQ-015 done  output  1  one-cycle pulse when a fill ends, normally or by abort.
REQ-016 MAX_LINE  parameter  default 119  last legal scanline.
REQ-017 MAX_COL  parameter  default 319  last legal pixel column.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, W0 (line/left word) and W1 (color/right word).
REQ-019 req_ready SHALL be 1 only in IDLE; the accept edge SHALL latch the normalized request and move the FSM to W0.
REQ-020 Normalization SHALL occur at accept: if top>bottom, swap the two lines; if left>right, swap the two columns; then clamp each line to MAX_LINE and each column to MAX_COL.
REQ-021 we SHALL equal (state is W0 or W1) AND NOT full, combinationally; a word is transferred on every clk edge with we=1.
REQ-022 In W0, data SHALL be {cur_line[6:0], left[8:0]}.
REQ-023 In W1, data SHALL be {color[2:0], 4'b0000, right[8:0]}.
REQ-024 data SHALL be 16'h0000 in IDLE.
REQ-025 W0 SHALL advance to W1 only on a transferred word; full=1 SHALL hold the state and data stable.
REQ-026 On a transferred W1 word: if cur_line==bottom or an abort is pending, the FSM SHALL go to IDLE with done=1 on the next cycle; otherwise cur_line SHALL increment by 1 and the FSM SHALL go to W0.
REQ-027 abort SHALL be latched as pending in any non-IDLE state.
REQ-028 A pending abort seen in W0 SHALL send the FSM to IDLE with no write and pulse done.
REQ-029 A pending abort seen in W1 SHALL complete the W1 word first, so that pairs are never split.
REQ-030 abort in IDLE SHALL be ignored and the pending flag SHALL be cleared on entering IDLE.
REQ-031 busy SHALL be 1 in W0/W1 and 0 in IDLE.
REQ-032 The first word SHALL appear no earlier than the cycle after accept, giving a 1-cycle accept-to-we latency when full=0.
REQ-033 Throughput SHALL be one word per cycle while full=0, i.e. 2*(bottom-top+1) cycles per fill.
REQ-034 A new request SHALL be accepted in the cycle after done at the earliest.

Reset
REQ-035 While reset=0, the FSM SHALL be in IDLE, with we=0, data=0, busy=0, done=0, req_ready=1, abort-pending=0, and all latched request registers at 0.
REQ-036 Reset asserted mid-fill SHALL drop we immediately (asynchronous); the partial pair is lost and no done pulse is issued.

Structure
REQ-037 The word field positions, the state encoding and the defaults of MAX_LINE/MAX_COL SHALL live in the shared draw package so that the Painter decode and this encode agree.
REQ-038 The normalize/clamp logic SHALL be one sub-module, span_normalize, which is combinational and is registered at accept by the parent.

Verification
REQ-039 Test 1: top=5, bottom=6, left=10, right=20, color=3'b101, full=0 -> the bench SHALL see exactly four words, 16'h0A0A, 16'hA014, 16'h0C0A, 16'hA014, on consecutive cycles, then done on the next cycle.
REQ-040 Test 2: top=50, bottom=40, left=300, right=2 -> the fill SHALL run lines 40..50 with left=2, right=300, giving 22 words.
REQ-041 Test 3: top=bottom=127, right=511 -> one pair SHALL be issued, with the line field=119 and right=319.
REQ-042 Test 4: full held high for 3 cycles during W1 -> we SHALL be 0 and data SHALL hold 16'h… (the W1 word) for 3 cycles, then transfer once with no duplicate and no loss.
REQ-043 Test 5: abort pulsed in W1 of line 2 of a 10-line fill -> the line-2 W1 word SHALL complete, no further words SHALL follow, done SHALL pulse once, and req_ready SHALL return to 1.
REQ-044 Test 6: reset pulled low while in W0 -> we, busy and req_ready SHALL take their reset values within the same cycle, and after release the next request SHALL restart cleanly.
